// File: rtl/common_pkg.sv
// -----------------------------------------------------------------------------
// common: shared bus types for the core <-> cache/memory interface.
//   ibus_*  : instruction fetch request/response (32-bit instruction word)
//   dbus_*  : data access request/response (64-bit beat, byte strobes)
//   cbus_*  : single shared cache/memory bus below the core
//   msize_t : access size encoding (bytes = 2**size)
//   mlen_t  : burst length encoding (beats - 1); only single beats exist
// -----------------------------------------------------------------------------
package common;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef enum logic [7:0] {
        MLEN1 = 8'd0
    } mlen_t;

    typedef logic [1:0] axi_burst_t;

    localparam axi_burst_t AXI_BURST_FIXED = 2'b00;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        msize_t      size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        mlen_t       len;
        axi_burst_t  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    // Select the 32-bit instruction word out of a 64-bit beat.
    function automatic logic [31:0] fetch_word(input logic [63:0] beat,
                                                input logic        hi);
        logic [31:0] word_s;
        if (hi) begin
            word_s = beat[63:32];
        end else begin
            word_s = beat[31:0];
        end
        return word_s;
    endfunction

endpackage

// File: rtl/core_bus_arbiter.sv
// -----------------------------------------------------------------------------
// core_bus_arbiter: merges the instruction bus and the data bus onto the single
// shared cache/memory bus. One single-beat transaction at a time. The data bus
// has priority; an anti-starvation counter hands the next arbitration to the
// instruction bus after STARVE_LIMIT consecutive data grants made while a fetch
// was waiting.
//
// Ports:
//   clk    in   core clock
//   reset  in   asynchronous active-low reset
//   ireq   in   instruction fetch request
//   iresp  out  instruction fetch response (registered, one-cycle pulse)
//   dreq   in   data access request
//   dresp  out  data access response (registered, one-cycle pulse)
//   creq   out  shared bus request (registered, held for the whole access)
//   cresp  in   shared bus response
// -----------------------------------------------------------------------------
module core_bus_arbiter
    import common::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output cbus_req_t  creq,
    input  cbus_resp_t cresp
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    localparam logic [2:0] STARVE_LIM_C = 3'(STARVE_LIMIT);

    arb_state_t state_r;
    arb_state_t next_state_s;
    logic       grant_i_s;
    logic       grant_d_s;
    logic       done_s;
    logic [2:0] starve_cnt_r;
    cbus_req_t  creq_r;
    ibus_resp_t iresp_r;
    dbus_resp_t dresp_r;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Arbitration and next-state decode; grants are only made from IDLE.
    always_comb begin
        next_state_s = state_r;
        grant_i_s    = 1'b0;
        grant_d_s    = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (ireq.valid && dreq.valid) begin
                    if (starve_cnt_r == STARVE_LIM_C) begin
                        grant_i_s = 1'b1;
                    end else begin
                        grant_d_s = 1'b1;
                    end
                end else if (ireq.valid) begin
                    grant_i_s = 1'b1;
                end else if (dreq.valid) begin
                    grant_d_s = 1'b1;
                end else begin
                    grant_i_s = 1'b0;
                end

                if (grant_i_s) begin
                    next_state_s = BUSY_I;
                end else if (grant_d_s) begin
                    next_state_s = BUSY_D;
                end else begin
                    next_state_s = IDLE;
                end
            end
            BUSY_I, BUSY_D: begin
                // ready without last is a wait: multi-beat is not supported.
                if (cresp.ready && cresp.last) begin
                    done_s       = 1'b1;
                    next_state_s = RESP;
                end else begin
                    next_state_s = state_r;
                end
            end
            RESP: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Anti-starvation counter: counts data grants that made a fetch wait.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_r <= 3'd0;
        end else if (grant_i_s) begin
            starve_cnt_r <= 3'd0;
        end else if (grant_d_s) begin
            if (!ireq.valid) begin
                starve_cnt_r <= 3'd0;
            end else if (starve_cnt_r != STARVE_LIM_C) begin
                starve_cnt_r <= starve_cnt_r + 3'd1;
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // Shared-bus request: latched at grant, held until the completing beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            creq_r <= '0;
        end else if (grant_i_s) begin
            creq_r.valid    <= 1'b1;
            creq_r.is_write <= 1'b0;
            creq_r.size     <= MSIZE4;
            creq_r.addr     <= ireq.addr;
            creq_r.strobe   <= 8'h00;
            creq_r.data     <= 64'h0;
            creq_r.len      <= MLEN1;
            creq_r.burst    <= AXI_BURST_FIXED;
        end else if (grant_d_s) begin
            creq_r.valid    <= 1'b1;
            creq_r.is_write <= (dreq.strobe != 8'h00);
            creq_r.size     <= dreq.size;
            creq_r.addr     <= dreq.addr;
            creq_r.strobe   <= dreq.strobe;
            creq_r.data     <= dreq.data;
            creq_r.len      <= MLEN1;
            creq_r.burst    <= AXI_BURST_FIXED;
        end else if (done_s) begin
            creq_r.valid    <= 1'b0;
        end else begin
            creq_r          <= creq_r;
        end
    end

    // Responses: the owner gets a one-cycle pulse carrying the captured beat;
    // outside that pulse both responses are all-zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iresp_r <= '0;
            dresp_r <= '0;
        end else if (done_s && (state_r == BUSY_I)) begin
            iresp_r.addr_ok <= 1'b1;
            iresp_r.data_ok <= 1'b1;
            iresp_r.data    <= fetch_word(cresp.data, creq_r.addr[2]);
            dresp_r         <= '0;
        end else if (done_s) begin
            dresp_r.addr_ok <= 1'b1;
            dresp_r.data_ok <= 1'b1;
            dresp_r.data    <= cresp.data;
            iresp_r         <= '0;
        end else begin
            iresp_r <= '0;
            dresp_r <= '0;
        end
    end

    assign creq  = creq_r;
    assign iresp = iresp_r;
    assign dresp = dresp_r;

endmodule

// File: tb/tb_core_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_core_bus_arbiter: directed, table-driven bench for core_bus_arbiter.
// A table of lone transactions is applied and checked cycle by cycle, followed
// by hand-written sequences for contention, reset mid-access and a requester
// that drops valid mid-access.
// -----------------------------------------------------------------------------
module tb_core_bus_arbiter;
    import common::*;

    typedef struct {
        logic        is_d;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          wait_cyc;
        logic        exp_wr;
        logic [63:0] exp_data;
    } vec_t;

    logic       clk;
    logic       reset;
    ibus_req_t  ireq;
    ibus_resp_t iresp;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    cbus_req_t  creq;
    cbus_resp_t cresp;

    int n_vec;
    int n_err;
    vec_t vecs[5];

    core_bus_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .ireq  (ireq),
        .iresp (iresp),
        .dreq  (dreq),
        .dresp (dresp),
        .creq  (creq),
        .cresp (cresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_iresp"}, 64'(iresp), 64'd0);
        check({tag, "_dresp_ok"}, 64'({dresp.addr_ok, dresp.data_ok}), 64'd0);
    endtask

    task automatic run_vec(input vec_t v);
        if (v.is_d) begin
            dreq.valid  = 1'b1;
            dreq.addr   = v.addr;
            dreq.size   = v.size;
            dreq.strobe = v.strobe;
            dreq.data   = v.wdata;
        end else begin
            ireq.valid = 1'b1;
            ireq.addr  = v.addr;
        end
        step();
        check("creq_valid", 64'(creq.valid), 64'd1);
        check("creq_is_write", 64'(creq.is_write), 64'(v.exp_wr));
        check("creq_addr", creq.addr, v.addr);
        check("creq_size", 64'(creq.size), v.is_d ? 64'(v.size) : 64'(MSIZE4));
        check("creq_strobe", 64'(creq.strobe), v.is_d ? 64'(v.strobe) : 64'd0);
        check("creq_len_burst", 64'({creq.len, creq.burst}), 64'd0);
        if (v.is_d) check("creq_data", creq.data, v.wdata);
        for (int w = 0; w < v.wait_cyc; w++) begin
            cresp.ready = (w == 3);
            cresp.last  = 1'b0;
            step();
            check("wait_valid", 64'(creq.valid), 64'd1);
            check("wait_addr", creq.addr, v.addr);
            check_quiet("wait");
        end
        cresp.ready = 1'b1;
        cresp.last  = 1'b1;
        cresp.data  = v.rdata;
        step();
        ireq.valid  = 1'b0;
        dreq.valid  = 1'b0;
        cresp       = '0;
        if (v.is_d) begin
            check("dresp_ok", 64'({dresp.addr_ok, dresp.data_ok}), 64'd3);
            if (!v.exp_wr) check("dresp_data", dresp.data, v.exp_data);
            check("iresp_idle", 64'(iresp), 64'd0);
        end else begin
            check("iresp_ok", 64'({iresp.addr_ok, iresp.data_ok}), 64'd3);
            check("iresp_data", 64'(iresp.data), v.exp_data);
            check("dresp_idle", 64'({dresp.addr_ok, dresp.data_ok}), 64'd0);
        end
        check("creq_released", 64'(creq.valid), 64'd0);
        step();
        check_quiet("post");
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        ireq  = '0;
        dreq  = '0;
        cresp = '0;

        vecs[0] = '{is_d:1'b0, addr:64'h8000_0004, size:MSIZE4, strobe:8'h00, wdata:64'h0,
                    rdata:64'h1111_2222_3333_4444, wait_cyc:0, exp_wr:1'b0, exp_data:64'h1111_2222};
        vecs[1] = '{is_d:1'b0, addr:64'h8000_0000, size:MSIZE4, strobe:8'h00, wdata:64'h0,
                    rdata:64'h1111_2222_3333_4444, wait_cyc:0, exp_wr:1'b0, exp_data:64'h3333_4444};
        vecs[2] = '{is_d:1'b1, addr:64'h8000_0010, size:MSIZE4, strobe:8'h0F, wdata:64'hAB,
                    rdata:64'h0, wait_cyc:0, exp_wr:1'b1, exp_data:64'h0};
        vecs[3] = '{is_d:1'b1, addr:64'h8000_0020, size:MSIZE8, strobe:8'h00, wdata:64'h0,
                    rdata:64'hDEAD_BEEF_CAFE_F00D, wait_cyc:2, exp_wr:1'b0, exp_data:64'hDEAD_BEEF_CAFE_F00D};
        vecs[4] = '{is_d:1'b0, addr:64'h8000_0104, size:MSIZE4, strobe:8'h00, wdata:64'h0,
                    rdata:64'hAAAA_BBBB_CCCC_DDDD, wait_cyc:10, exp_wr:1'b0, exp_data:64'hAAAA_BBBB};

        // Reset state.
        step();
        step();
        check("rst_creq_valid", 64'(creq.valid), 64'd0);
        check("rst_creq_addr", creq.addr, 64'd0);
        check("rst_creq_data", creq.data, 64'd0);
        check("rst_creq_misc", 64'({creq.is_write, creq.size, creq.strobe, creq.len, creq.burst}), 64'd0);
        check("rst_iresp", 64'(iresp), 64'd0);
        check("rst_dresp_data", dresp.data, 64'd0);
        check("rst_dresp_ok", 64'({dresp.addr_ok, dresp.data_ok}), 64'd0);
        reset = 1'b1;
        step();

        // Stray bus response while idle is ignored.
        cresp = '{ready:1'b1, last:1'b1, data:64'h1234};
        step();
        cresp = '0;
        check("idle_ready_valid", 64'(creq.valid), 64'd0);
        check_quiet("idle_ready");
        step();

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
        end

        // Contention: both held valid; expect D,D,D,D,I repeating.
        ireq.valid  = 1'b1;
        ireq.addr   = 64'h8000_1000;
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h9000_0000;
        dreq.size   = MSIZE8;
        dreq.strobe = 8'h00;
        dreq.data   = 64'h0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("cont_grant_addr", creq.addr, (i % 5 == 4) ? 64'h8000_1000 : 64'h9000_0000);
            cresp = '{ready:1'b1, last:1'b1, data:64'h0};
            step();
            cresp = '0;
            check("cont_iresp_ok", 64'(iresp.data_ok), (i % 5 == 4) ? 64'd1 : 64'd0);
            check("cont_dresp_ok", 64'(dresp.data_ok), (i % 5 == 4) ? 64'd0 : 64'd1);
            if (i == 9) begin
                ireq.valid = 1'b0;
                dreq.valid = 1'b0;
            end
            step();
        end

        // Asynchronous reset during a data access.
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h8000_0040;
        dreq.size   = MSIZE8;
        dreq.strobe = 8'hFF;
        dreq.data   = 64'h5A5A;
        step();
        check("rstmid_busy", 64'(creq.valid), 64'd1);
        dreq.valid = 1'b0;
        reset = 1'b0;
        #1;
        check("rstmid_valid_drop", 64'(creq.valid), 64'd0);
        step();
        check_quiet("rstmid_hold");
        reset = 1'b1;
        step();
        check_quiet("rstmid_release");
        ireq.valid = 1'b1;
        ireq.addr  = 64'h8000_0008;
        step();
        check("rstmid_fetch_valid", 64'(creq.valid), 64'd1);
        check("rstmid_fetch_addr", creq.addr, 64'h8000_0008);
        cresp = '{ready:1'b1, last:1'b1, data:64'h5555_6666_7777_8888};
        step();
        cresp = '0;
        ireq.valid = 1'b0;
        check("rstmid_fetch_ok", 64'({iresp.addr_ok, iresp.data_ok}), 64'd3);
        check("rstmid_fetch_data", 64'(iresp.data), 64'h7777_8888);
        check("rstmid_no_stale_d", 64'({dresp.addr_ok, dresp.data_ok}), 64'd0);
        step();

        // Requester drops valid mid-transaction.
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h8000_0030;
        dreq.size   = MSIZE8;
        dreq.strobe = 8'h00;
        step();
        dreq = '0;
        step();
        check("drop_valid_held", 64'(creq.valid), 64'd1);
        check("drop_addr_held", creq.addr, 64'h8000_0030);
        cresp = '{ready:1'b1, last:1'b1, data:64'h0123_4567_89AB_CDEF};
        step();
        cresp = '0;
        check("drop_dresp_ok", 64'(dresp.data_ok), 64'd1);
        check("drop_dresp_data", dresp.data, 64'h0123_4567_89AB_CDEF);
        step();
        check_quiet("drop_single_pulse");
        ireq.valid = 1'b1;
        ireq.addr  = 64'h8000_000C;
        step();
        check("drop_next_addr", creq.addr, 64'h8000_000C);
        check("drop_next_wr", 64'(creq.is_write), 64'd0);
        cresp = '{ready:1'b1, last:1'b1, data:64'hCAFE_0001_BEEF_0002};
        step();
        cresp = '0;
        ireq.valid = 1'b0;
        check("drop_next_data", 64'(iresp.data), 64'hCAFE_0001);
        check("drop_next_ok", 64'(iresp.data_ok), 64'd1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
